less_arb: RTL
=============

LESS_ARB -- requirements
Module: less_arb

Interface
REQ-001 SHALL have parameter W, default 6, operand width in bits (two's complement); legal values are W >= 2.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 presents an operand pair.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  the operand pair is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  W  signed operands, A and B.
REQ-007 SHALL have ports rsp0_valid / rsp1_valid  output  1  a result is pending for requester 0/1.
REQ-008 SHALL have ports rsp0_ready / rsp1_ready  input  1  requester 0/1 takes the result.
REQ-009 SHALL have port rsp_lt  output  1  result, 1 when A < B signed; valid only while rsp0_valid or rsp1_valid is high.
REQ-010 SHALL have ports neg_a / neg_b  output  1  sign bit of the latched A / B.
REQ-011 SHALL have port busy  output  1  the FSM is not in IDLE.
REQ-012 SHALL have port grant_id  output  1  requester owning the current transaction.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, CMP, RESP.
- IDLE to LOAD on any accepted request.
- LOAD to CMP unconditionally.
- CMP to RESP unconditionally.
- RESP to IDLE when rsp<grant_id>_ready is high; otherwise the FSM holds in RESP.
REQ-014 SHALL assert reqN_ready combinationally only in IDLE, only for the arbitration winner, and only while that requester's reqN_valid is high; at most one ready SHALL be high in any cycle.
REQ-015 SHALL, on acceptance, latch the winner's A and B and set grant_id to the winner.
REQ-016 SHALL, in LOAD, register neg_a = A[W-1] and neg_b = B[W-1].
REQ-017 SHALL, in CMP, register the signed less-than result as follows.
- Signs differ: rsp_lt = neg_a.
- Signs equal: rsp_lt = 1 when the W-bit raw A is less than the W-bit raw B, else 0.
- A == B: rsp_lt = 0.
- The minimum value (-2^(W-1)) SHALL compare correctly without negation overflow.
REQ-018 SHALL, in RESP, assert rsp<grant_id>_valid only; the other rsp valid stays low. rsp_lt, neg_a and neg_b SHALL stay stable until the handshake completes.
REQ-019 SHALL give a latency of 3 cycles from acceptance edge to rsp_valid high; maximum throughput is one transaction per 4 cycles.
REQ-020 SHALL arbitrate round-robin (default build): when both requesters are valid, the one not granted last wins; a lone valid requester always wins.
REQ-021 SHALL ignore requests while busy; new input values during that time SHALL not affect the latched operands.
REQ-022 SHALL allow rsp ready to be high before valid, so a single-cycle RESP is possible.

Reset
REQ-023 SHALL, on a clock edge with rst_n low, enter IDLE and clear all outputs to 0: ready, rsp valids, rsp_lt, neg_a, neg_b, busy, grant_id.
REQ-024 SHALL reset last-grant to 1, so that requester 0 wins the first tie.
REQ-025 SHALL abort any in-flight transaction on reset in any state, with no response issued.

Configuration
REQ-026 SHALL support macro LESS_ARB_FIXED_PRIO_EN.
- When defined: requester 0 always wins a tie, and the last-grant register is not used.
- When undefined: round-robin per REQ-020.

Verification
REQ-027 SHALL cover the mixed-sign boundary: W=6, req0 A=-32 (6'b100000), B=31 -> rsp0_valid 3 cycles after accept, rsp_lt=1, neg_a=1, neg_b=0.
REQ-028 SHALL cover both operands negative: req1 A=-1, B=-2 -> rsp_lt=0; then A=-2, B=-1 -> rsp_lt=1; then A=-32, B=-32 -> rsp_lt=0.
REQ-029 SHALL cover a round-robin tie: both valid continuously from reset with rsp readys tied high -> grant order 0,1,0,1, and accepts every 4 cycles.
REQ-030 SHALL cover backpressure: rsp0_ready held low for 5 cycles in RESP -> rsp0_valid and rsp_lt stable, busy=1, req1_ready=0 throughout.
REQ-031 SHALL cover reset mid-operation: rst_n low during CMP -> next cycle IDLE, all outputs 0, and no rsp_valid observed.
REQ-032 SHALL cover the fixed-priority build: LESS_ARB_FIXED_PRIO_EN defined, both valid continuously -> every grant goes to requester 0.

Source files
------------

// File: rtl/less_arb.sv
// -----------------------------------------------------------------------------
// less_arb
//   Two-requester arbiter in front of a sequential signed less-than comparator.
//   An accepted operand pair flows IDLE -> LOAD -> CMP -> RESP. LOAD captures
//   the operand sign bits and CMP resolves A < B. RESP holds the result until
//   the granted requester takes it. The response appears three cycles after
//   the accept cycle, so at most one transaction completes every four cycles.
//
// Configuration macro:
//   LESS_ARB_FIXED_PRIO_EN  defined   : requester 0 always wins a tie.
//                           undefined : round-robin; on a tie the requester
//                                       not granted last wins.
//
// Parameters:
//   W            operand width in bits, two's complement (W >= 2)
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   req0_valid   requester 0 presents an operand pair
//   req0_ready   requester 0's pair is accepted this cycle
//   req0_a/b     requester 0 operands A and B (signed)
//   req1_valid   requester 1 presents an operand pair
//   req1_ready   requester 1's pair is accepted this cycle
//   req1_a/b     requester 1 operands A and B (signed)
//   rsp0_valid   result pending for requester 0
//   rsp0_ready   requester 0 takes the result
//   rsp1_valid   result pending for requester 1
//   rsp1_ready   requester 1 takes the result
//   rsp_lt       1 when A < B (signed); meaningful while a rsp valid is high
//   neg_a/neg_b  sign bits of the latched A / B
//   busy         transaction in flight (FSM not in IDLE)
//   grant_id     requester owning the current transaction
// -----------------------------------------------------------------------------
module less_arb #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic         rsp_lt,
    output logic         neg_a,
    output logic         neg_b,
    output logic         busy,
    output logic         grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CMP  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_neg_a;
    logic           r_neg_b;
    logic           r_lt;
    logic           r_grant;

    logic           w_win;
    logic           w_idle;
    logic           w_accept;
    logic           w_rsp_ready;
    logic           w_lt;

    // -------------------------------------------------------------------------
    // Arbitration. w_win names the requester that would be granted this cycle.
    // With no one valid the value is irrelevant because nothing is accepted.
    // -------------------------------------------------------------------------
`ifdef LESS_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = req0_valid ? 1'b0 : 1'b1;
    end
`else
    logic r_last;   // requester granted most recently

    always_comb begin
        if (req0_valid && req1_valid) begin
            w_win = ~r_last;
        end else begin
            w_win = req0_valid ? 1'b0 : 1'b1;
        end
    end

    // Reset value of 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_win;
        end
    end
`endif

    // Ready is gated by rst_n so nothing is seen as accepted on a reset edge.
    assign w_idle     = (r_state == IDLE);
    assign req0_ready = rst_n && w_idle && req0_valid && !w_win;
    assign req1_ready = rst_n && w_idle && req1_valid &&  w_win;
    assign w_accept   = req0_ready || req1_ready;

    // -------------------------------------------------------------------------
    // Signed compare without negation. When the signs differ, the negative
    // operand is the smaller one. When the signs match, the raw unsigned order
    // of the two's-complement patterns equals the signed order, which also
    // handles the minimum value. Equal operands give 0.
    // -------------------------------------------------------------------------
    assign w_lt = (r_neg_a != r_neg_b) ? r_neg_a : (r_a < r_b);

    assign w_rsp_ready = r_grant ? rsp1_ready : rsp0_ready;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = LOAD;
            LOAD: w_state_next = CMP;
            CMP:  w_state_next = RESP;
            RESP: if (w_rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operands are captured only on acceptance, so input changes
    // while busy cannot disturb the transaction in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_grant <= 1'b0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_win;
                r_a     <= w_win ? req1_a : req0_a;
                r_b     <= w_win ? req1_b : req0_b;
            end
            if (r_state == LOAD) begin
                r_neg_a <= r_a[W-1];
                r_neg_b <= r_b[W-1];
            end
            if (r_state == CMP) begin
                r_lt <= w_lt;
            end
        end
    end

    assign rsp0_valid = (r_state == RESP) && !r_grant;
    assign rsp1_valid = (r_state == RESP) &&  r_grant;
    assign rsp_lt     = r_lt;
    assign neg_a      = r_neg_a;
    assign neg_b      = r_neg_b;
    assign busy       = !w_idle;
    assign grant_id   = r_grant;

endmodule
